// File: rtl/nec_ir_pkg.sv
// NEC IR transmitter shared definitions: FSM state encoding, default
// protocol timing (in carrier periods) and a small helper for sizing counters.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_ON,
    ST_LEAD_OFF,
    ST_BIT_ON,
    ST_BIT_OFF,
    ST_END_ON,
    ST_GUARD
  } state_t;

  // 50 MHz / 1316 ~= 38 kHz carrier
  localparam int DEF_CARRIER_HALF   = 658;
  localparam int DEF_CARRIER_PERIOD = 2 * DEF_CARRIER_HALF;

  // Durations in carrier periods
  localparam int DEF_LEADER_ON  = 342;
  localparam int DEF_LEADER_OFF = 171;
  localparam int DEF_REPEAT_OFF = 85;
  localparam int DEF_BIT_ON     = 21;
  localparam int DEF_ZERO_OFF   = 21;
  localparam int DEF_ONE_OFF    = 64;
  localparam int DEF_GUARD      = 1520;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nec_ir_tx_carrier_gen.sv
// Carrier divider for the NEC transmitter.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   restart      - hold the divider at the start of a period
//   enable       - advance the divider
//   level        - 1 during the first HALF cycles of each period
//   period_tick  - last cycle of a carrier period
//   pre_tick     - second-to-last cycle of a carrier period, lets the FSM
//                  register outputs that must line up with period_tick
module ir_carrier_gen #(
  parameter int HALF = 658
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic level,
  output logic period_tick,
  output logic pre_tick
);

  localparam int PERIOD = 2 * HALF;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign level       = (cnt < CW'(HALF));
  assign period_tick = enable && (cnt == CW'(PERIOD - 1));
  assign pre_tick    = enable && (cnt == CW'(PERIOD - 2));

endmodule

// File: rtl/nec_ir_tx.sv
// NEC-protocol IR transmitter: sends a full address/command frame or a
// repeat code as a 38 kHz modulated burst train, then enforces a guard gap.
// Ports:
//   CLOCK_50, RST        - system clock, synchronous active-high reset
//   TX_VALID/TX_READY    - full-frame request handshake
//   TX_ADDR, TX_CMD      - frame payload, latched on accept
//   TX_REPEAT            - repeat-code request (loses to TX_VALID)
//   TX_BUSY              - frame or guard in progress
//   TX_DONE              - one-cycle pulse on the last cycle of the end mark
//   IRDA_TXD             - modulated IR output, idle low
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | ready, carrier held at period start
// LEAD_ON   | 9 ms leader mark
// LEAD_OFF  | leader space (4.5 ms frame / 2.25 ms repeat)
// BIT_ON    | 560 us data mark
// BIT_OFF   | data space, length chosen by current LSB
// END_ON    | final 560 us mark, TX_DONE on its last cycle
// GUARD     | enforced silence before accepting the next request
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int CARRIER_HALF = DEF_CARRIER_HALF,
  parameter int LEADER_ON    = DEF_LEADER_ON,
  parameter int LEADER_OFF   = DEF_LEADER_OFF,
  parameter int REPEAT_OFF   = DEF_REPEAT_OFF,
  parameter int BIT_ON       = DEF_BIT_ON,
  parameter int ZERO_OFF     = DEF_ZERO_OFF,
  parameter int ONE_OFF      = DEF_ONE_OFF,
  parameter int GUARD        = DEF_GUARD
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic [7:0] TX_ADDR,
  input  logic [7:0] TX_CMD,
  input  logic       TX_REPEAT,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       IRDA_TXD
);

  localparam int PMAX = max2(max2(max2(LEADER_ON, LEADER_OFF), max2(REPEAT_OFF, BIT_ON)),
                             max2(max2(ZERO_OFF, ONE_OFF), GUARD));
  localparam int PW   = $clog2(PMAX + 1);

  state_t        state;
  logic [PW-1:0] phase;     // carrier periods left in the current phase, minus one
  logic [31:0]   shreg;
  logic [4:0]    bit_idx;
  logic          rpt;
  logic          level, period_tick, pre_tick;
  logic          mark;

  assign mark = (state == ST_LEAD_ON) || (state == ST_BIT_ON) || (state == ST_END_ON);

  ir_carrier_gen #(.HALF(CARRIER_HALF)) u_carrier (
    .clk        (CLOCK_50),
    .rst        (RST),
    .restart    (state == ST_IDLE),
    .enable     (state != ST_IDLE),
    .level      (level),
    .period_tick(period_tick),
    .pre_tick   (pre_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state    <= ST_IDLE;
      phase    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      rpt      <= 1'b0;
      TX_READY <= 1'b1;
      TX_BUSY  <= 1'b0;
      TX_DONE  <= 1'b0;
      IRDA_TXD <= 1'b0;
    end else begin
      // One-cycle lag behind the divider: each mark rises one cycle after entry
      IRDA_TXD <= mark && level;
      // Registered a cycle early so the pulse sits on END_ON's final cycle
      TX_DONE  <= (state == ST_END_ON) && (phase == '0) && pre_tick;

      case (state)
        ST_IDLE: begin
          if ((TX_VALID || TX_REPEAT) && TX_READY) begin
            state    <= ST_LEAD_ON;
            phase    <= PW'(LEADER_ON - 1);
            rpt      <= ~TX_VALID;
            shreg    <= {~TX_CMD, TX_CMD, ~TX_ADDR, TX_ADDR};
            bit_idx  <= '0;
            TX_READY <= 1'b0;
            TX_BUSY  <= 1'b1;
          end
        end
        default: begin
          if (period_tick) begin
            if (phase != '0) begin
              phase <= phase - 1'b1;
            end else begin
              case (state)
                ST_LEAD_ON: begin
                  state <= ST_LEAD_OFF;
                  phase <= rpt ? PW'(REPEAT_OFF - 1) : PW'(LEADER_OFF - 1);
                end
                ST_LEAD_OFF: begin
                  state <= rpt ? ST_END_ON : ST_BIT_ON;
                  phase <= PW'(BIT_ON - 1);
                end
                ST_BIT_ON: begin
                  state <= ST_BIT_OFF;
                  phase <= shreg[0] ? PW'(ONE_OFF - 1) : PW'(ZERO_OFF - 1);
                end
                ST_BIT_OFF: begin
                  shreg <= shreg >> 1;
                  phase <= PW'(BIT_ON - 1);
                  if (bit_idx == 5'd31) begin
                    state <= ST_END_ON;
                  end else begin
                    bit_idx <= bit_idx + 1'b1;
                    state   <= ST_BIT_ON;
                  end
                end
                ST_END_ON: begin
                  state <= ST_GUARD;
                  phase <= PW'(GUARD - 1);
                end
                ST_GUARD: begin
                  state    <= ST_IDLE;
                  TX_READY <= 1'b1;
                  TX_BUSY  <= 1'b0;
                end
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx with shortened timing. A reference model turns each
// request into a list of (mark/space, periods) segments and then into an
// expected per-cycle IRDA_TXD waveform; handshake and TX_DONE timing follow
// from the total segment length.
module tb_nec_ir_tx;
  localparam int HALF = 3;
  localparam int P    = 2 * HALF;
  localparam int LO   = 5;
  localparam int LF   = 3;
  localparam int RO   = 2;
  localparam int BON  = 2;
  localparam int ZOFF = 1;
  localparam int OOFF = 3;
  localparam int GRD  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       tx_ready, tx_busy, tx_done, irda;

  int tests = 0;
  int fails = 0;

  int seg_len[$];
  bit seg_mark[$];
  bit exp_wave[$];

  always #10 clk = ~clk;

  nec_ir_tx #(
    .CARRIER_HALF(HALF), .LEADER_ON(LO), .LEADER_OFF(LF), .REPEAT_OFF(RO),
    .BIT_ON(BON), .ZERO_OFF(ZOFF), .ONE_OFF(OOFF), .GUARD(GRD)
  ) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .TX_ADDR  (tx_addr),
    .TX_CMD   (tx_cmd),
    .TX_REPEAT(tx_repeat),
    .TX_BUSY  (tx_busy),
    .TX_DONE  (tx_done),
    .IRDA_TXD (irda)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void add_seg(input bit m, input int n);
    seg_mark.push_back(m);
    seg_len.push_back(n);
  endfunction

  // Expected waveform, one entry per cycle after the accept edge
  function automatic void build_model(input bit is_rpt, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] word;
    seg_len.delete();
    seg_mark.delete();
    exp_wave.delete();
    word = {~c, c, ~a, a};
    add_seg(1'b1, LO);
    if (is_rpt) begin
      add_seg(1'b0, RO);
    end else begin
      add_seg(1'b0, LF);
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, BON);
        add_seg(1'b0, word[i] ? OOFF : ZOFF);
      end
    end
    add_seg(1'b1, BON);
    foreach (seg_len[s])
      for (int k = 0; k < seg_len[s] * P; k++)
        exp_wave.push_back(seg_mark[s] && (k >= 1) && (((k - 1) % P) < HALF));
  endfunction

  function automatic int bit_off_start(input logic [7:0] a, input logic [7:0] c, input int idx);
    logic [31:0] w;
    int t;
    w = {~c, c, ~a, a};
    t = (LO + LF) * P;
    for (int i = 0; i < idx; i++) t += (BON + (w[i] ? OOFF : ZOFF)) * P;
    return t + BON * P;
  endfunction

  // Issue a request at the current negedge and check every cycle until idle.
  // inject_at: cycle at which a conflicting request is pulsed (-1 none).
  // abort_at:  cycle at which RST is asserted for one edge (-1 none).
  task automatic send(input string name, input bit v, input bit r,
                      input logic [7:0] a, input logic [7:0] c,
                      input int inject_at, input int abort_at);
    int total, span, e_txd, e_done, e_busy, e_ready, done_at, exp_done_at;
    logic exp_txd;
    build_model(!v, a, c);
    total = exp_wave.size();
    span  = total + GRD * P;
    e_txd = 0; e_done = 0; e_busy = 0; e_ready = 0; done_at = -1;
    exp_done_at = (abort_at < 0) ? total - 1 : -1;
    tx_valid = v; tx_repeat = r; tx_addr = a; tx_cmd = c;
    for (int j = 0; j <= span; j++) begin
      @(negedge clk);
      if (j == 0) begin
        tx_valid = 1'b0; tx_repeat = 1'b0;
        tx_addr = 8'($urandom); tx_cmd = 8'($urandom);
      end
      exp_txd = (j < total) ? exp_wave[j] : 1'b0;
      if (irda !== exp_txd) e_txd++;
      if (tx_done !== (j == total - 1)) e_done++;
      if (tx_done === 1'b1 && done_at < 0) done_at = j;
      if (tx_busy !== (j < span)) e_busy++;
      if (tx_ready !== (j >= span)) e_ready++;
      if (j == inject_at) begin
        tx_valid = 1'b1; tx_repeat = 1'b1; tx_addr = ~a; tx_cmd = ~c;
      end else if (j == inject_at + 1) begin
        tx_valid = 1'b0; tx_repeat = 1'b0;
      end
      if (j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_bit($sformatf("%s abort txd", name), irda, 1'b0);
        check_bit($sformatf("%s abort ready", name), tx_ready, 1'b1);
        check_bit($sformatf("%s abort busy", name), tx_busy, 1'b0);
        check_bit($sformatf("%s abort done", name), tx_done, 1'b0);
        rst = 1'b0;
        break;
      end
    end
    check_int($sformatf("%s txd mismatch cycles", name), e_txd, 0);
    check_int($sformatf("%s done mismatch cycles", name), e_done, 0);
    check_int($sformatf("%s done cycle", name), done_at, exp_done_at);
    check_int($sformatf("%s busy mismatch cycles", name), e_busy, 0);
    check_int($sformatf("%s ready mismatch cycles", name), e_ready, 0);
  endtask

  initial begin
    int quiet_err;
    bit v, r;
    repeat (3) @(negedge clk);
    check_bit("reset txd", irda, 1'b0);
    check_bit("reset ready", tx_ready, 1'b1);
    check_bit("reset busy", tx_busy, 1'b0);
    check_bit("reset done", tx_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    send("frame_00_16", 1'b1, 1'b0, 8'h00, 8'h16, -1, -1);
    send("repeat", 1'b0, 1'b1, 8'h00, 8'h00, -1, -1);
    send("both_a5_3c", 1'b1, 1'b1, 8'hA5, 8'h3C, -1, -1);

    quiet_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irda !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) quiet_err++;
    end
    check_int("no follow-on repeat", quiet_err, 0);

    send("busy_inject", 1'b1, 1'b0, 8'h12, 8'h34, 100, -1);
    send("abort_bit10", 1'b1, 1'b0, 8'h5A, 8'h81, -1, bit_off_start(8'h5A, 8'h81, 10) + 2);
    send("after_abort", 1'b1, 1'b0, 8'hC3, 8'h7E, -1, -1);

    for (int n = 0; n < 4; n++) begin
      v = 1'($urandom_range(0, 1));
      r = v ? 1'($urandom_range(0, 1)) : 1'b1;
      send($sformatf("random%0d", n), v, r, 8'($urandom), 8'($urandom),
           int'($urandom_range(1, 50)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
